alu16: RTL and testbench
========================

ALU16 -- requirements
Module: alu16

Interface
REQ-001 Parameter WIDTH, default 16, data width of operands and result; all values below assume 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B (shift amount for shift ops).
REQ-006 select  input  3  operation code.
REQ-007 in_valid  input  1  operands/select are valid this cycle.
REQ-008 result  output  WIDTH  registered operation result.
REQ-009 out_valid  output  1  result/flags hold a new value this cycle.
REQ-010 zero, carry, overflow, negative  output  1 each  registered status flags.

Function
REQ-011 Opcodes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 SHL A<<B[3:0]; 110 SHR logical A>>B[3:0]; 111 SLT, result 1 if signed A < signed B, else 0.
REQ-012 Arithmetic SHALL wrap modulo 2^WIDTH; result is the low WIDTH bits.
REQ-013 Shift amount SHALL use B[3:0] only; B[15:4] ignored; amount 0 returns A unchanged; vacated bits filled with 0.
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on result/flags at edge N with out_valid=1 during the following cycle.
REQ-015 When in_valid=0 at an edge, result and flags SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 No backpressure; a new operation may be issued every cycle.
REQ-017 zero SHALL be 1 when the new result equals 0.
REQ-018 negative SHALL equal result[WIDTH-1].
REQ-019 carry SHALL be: ADD carry-out of bit WIDTH-1; SUB 1 when A < B unsigned (borrow); all other ops 0.
REQ-020 overflow SHALL be: ADD 1 when A,B same sign and result sign differs; SUB 1 when A,B differ in sign and result sign differs from A; all other ops 0.
REQ-021 The block SHALL be purely synchronous, no latches, no combinational path from inputs to outputs.

Reset
REQ-022 While reset=1 at a rising edge, result SHALL become 0, all flags 0, out_valid 0; reset overrides in_valid.
REQ-023 An operation issued in the cycle reset is asserted SHALL be discarded; first valid output appears 1 cycle after the first in_valid edge with reset=0.

Configuration
REQ-024 Macro ALU_FLAGS_EN SHALL control flag generation.
REQ-025 With ALU_FLAGS_EN defined, zero/carry/overflow/negative SHALL behave per REQ-017..020.
REQ-026 Without ALU_FLAGS_EN, the flag ports SHALL remain present and be driven constant 0; result and out_valid behaviour unchanged.

Verification
REQ-027 Reset 2 cycles -> result=0x0000, out_valid=0, all flags 0.
REQ-028 Back-to-back issue, one per cycle: ADD 9,23 -> 32; SUB 20,10 -> 10; AND 16,16 -> 16; OR 32,14 -> 46; XOR 8,7 -> 15; SHL 20,3 -> 160; each one cycle after issue with out_valid=1.
REQ-029 ADD 0xFFFF,0x0001 -> result 0x0000, zero=1, carry=1, overflow=0; ADD 0x7FFF,0x0001 -> 0x8000, overflow=1, negative=1.
REQ-030 SUB 0x8000,0x0001 -> 0x7FFF, overflow=1; SUB 3,5 -> 0xFFFE, carry=1, negative=1.
REQ-031 SHR 0x8000,0x0013 -> 0x1000 (B[3:0]=3); SLT 0xFFFF,0x0001 -> 1; SLT 1,0xFFFF -> 0.
REQ-032 Issue ADD 1,1 then drop in_valid -> result holds 2, out_valid 0; assert reset with in_valid=1 -> outputs 0, operation discarded.

Source files
------------

// File: rtl/alu16.sv
// alu16: single-cycle registered 16-bit ALU with valid tag.
// Optional status flags are built only when ALU_FLAGS_EN is defined.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;

  // Combinational operation result for the current opcode
  always_comb begin
    alu_res = '0;
    case (select)
      OP_ADD: alu_res = A + B;
      OP_SUB: alu_res = A - B;
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SHL: alu_res = A << B[3:0];
      OP_SHR: alu_res = A >> B[3:0];
      OP_SLT: alu_res[0] = $signed(A) < $signed(B);
      default: alu_res = '0;
    endcase
  end

  // Capture a new result on valid issue, otherwise hold
  always_comb begin
    result_d    = result_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = alu_res;
    end
  end

  // Result and valid registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
  logic zero_q, zero_d;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic neg_q, neg_d;
  logic sa, sb, sr;

  assign sa = A[WIDTH-1];
  assign sb = B[WIDTH-1];
  assign sr = alu_res[WIDTH-1];

  // Flag next-state: add carry is sum<A, sub carry is unsigned borrow
  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    if (in_valid) begin
      zero_d  = (alu_res == '0);
      neg_d   = sr;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      if (select == OP_ADD) begin
        carry_d = (alu_res < A);
        ovf_d   = (sa == sb) && (sr != sa);
      end else if (select == OP_SUB) begin
        carry_d = (A < B);
        ovf_d   = (sa != sb) && (sr != sa);
      end
    end
  end

  // Flag registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign negative = neg_q;
`else
  assign zero     = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: vector table, directed corner sequences and random ops
// checked against an integer-arithmetic reference model.
module tb_alu16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B;
  logic [2:0]  select;
  logic        in_valid;
  logic [15:0] result;
  logic        out_valid;
  logic        zero, carry, overflow, negative;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_r;
  logic [3:0]  m_f;
  logic        m_v;

`ifdef ALU_FLAGS_EN
  localparam logic [3:0] FMASK = 4'hF;
`else
  localparam logic [3:0] FMASK = 4'h0;
`endif

  alu16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .select(select),
    .in_valid(in_valid), .result(result), .out_valid(out_valid),
    .zero(zero), .carry(carry), .overflow(overflow),
    .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  s;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t tbl[16];

  // flags packed as {zero, carry, overflow, negative}
  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] s, output logic [15:0] r,
                                 output logic [3:0] f);
    int ua, ub, sa, sb, full, sf;
    logic c, o;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 0; o = 0; full = 0;
    case (s)
      3'd0: begin
        full = ua + ub; sf = sa + sb;
        c = full > 65535; o = (sf > 32767) || (sf < -32768);
      end
      3'd1: begin
        full = ua - ub; sf = sa - sb;
        c = ua < ub; o = (sf > 32767) || (sf < -32768);
      end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: full = ua << (ub % 16);
      3'd6: full = ua >> (ub % 16);
      default: full = (sa < sb) ? 1 : 0;
    endcase
    r = 16'(full);
    f = {r == 16'h0, c, o, r[15]} & FMASK;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] s);
    @(negedge clk);
    reset = rst; in_valid = v; A = a; B = b; select = s;
    @(posedge clk);
    if (rst) begin
      m_r = 16'h0; m_f = 4'h0; m_v = 1'b0;
    end else if (v) begin
      ref_op(a, b, s, m_r, m_f); m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    #1;
    chk("model_result", result, m_r);
    chk("model_valid", {15'h0, out_valid}, {15'h0, m_v});
    chk("model_flags", {12'h0, zero, carry, overflow, negative}, {12'h0, m_f});
  endtask

  initial begin
    tbl[0]  = '{16'd9,     16'd23,    3'd0, 16'd32,    4'b0000};
    tbl[1]  = '{16'd20,    16'd10,    3'd1, 16'd10,    4'b0000};
    tbl[2]  = '{16'd16,    16'd16,    3'd2, 16'd16,    4'b0000};
    tbl[3]  = '{16'd32,    16'd14,    3'd3, 16'd46,    4'b0000};
    tbl[4]  = '{16'd8,     16'd7,     3'd4, 16'd15,    4'b0000};
    tbl[5]  = '{16'd20,    16'd3,     3'd5, 16'd160,   4'b0000};
    tbl[6]  = '{16'hFFFF,  16'h0001,  3'd0, 16'h0000,  4'b1100};
    tbl[7]  = '{16'h7FFF,  16'h0001,  3'd0, 16'h8000,  4'b0011};
    tbl[8]  = '{16'h8000,  16'h0001,  3'd1, 16'h7FFF,  4'b0010};
    tbl[9]  = '{16'd3,     16'd5,     3'd1, 16'hFFFE,  4'b0101};
    tbl[10] = '{16'h8000,  16'h0013,  3'd6, 16'h1000,  4'b0000};
    tbl[11] = '{16'hFFFF,  16'h0001,  3'd7, 16'h0001,  4'b0000};
    tbl[12] = '{16'h0001,  16'hFFFF,  3'd7, 16'h0000,  4'b1000};
    tbl[13] = '{16'h1234,  16'h0010,  3'd5, 16'h1234,  4'b0000};
    tbl[14] = '{16'hABCD,  16'h000F,  3'd6, 16'h0001,  4'b0000};
    tbl[15] = '{16'hF0F0,  16'h0F0F,  3'd2, 16'h0000,  4'b1000};

    reset = 1'b1; in_valid = 1'b1; A = 16'h5; B = 16'h6; select = 3'd0;
    m_r = 16'h0; m_f = 4'h0; m_v = 1'b0;

    // reset for two cycles with a live operation present
    step(1'b1, 1'b1, 16'h5, 16'h6, 3'd0);
    step(1'b1, 1'b1, 16'h5, 16'h6, 3'd0);
    chk("reset_result", result, 16'h0000);
    chk("reset_valid", {15'h0, out_valid}, 16'h0);

    // back-to-back table vectors, one per cycle
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].s);
      chk($sformatf("vec%0d_result", i), result, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), {15'h0, out_valid}, 16'h1);
      chk($sformatf("vec%0d_flags", i),
          {12'h0, zero, carry, overflow, negative},
          {12'h0, tbl[i].f & FMASK});
    end

    // hold on idle, then reset discards a live issue
    step(1'b0, 1'b1, 16'd1, 16'd1, 3'd0);
    step(1'b0, 1'b0, 16'd7, 16'd9, 3'd0);
    chk("hold_result", result, 16'd2);
    chk("hold_valid", {15'h0, out_valid}, 16'h0);
    step(1'b0, 1'b0, 16'd7, 16'd9, 3'd1);
    chk("hold2_result", result, 16'd2);
    step(1'b1, 1'b1, 16'd5, 16'd5, 3'd0);
    chk("rst_discard_result", result, 16'h0);
    chk("rst_discard_valid", {15'h0, out_valid}, 16'h0);
    step(1'b0, 1'b0, 16'd5, 16'd5, 3'd0);
    chk("post_rst_result", result, 16'h0);
    chk("post_rst_valid", {15'h0, out_valid}, 16'h0);
    step(1'b0, 1'b1, 16'd5, 16'd5, 3'd0);
    chk("first_after_rst", result, 16'd10);

    // random ops with idle gaps and rare resets
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = {ra[15], 15'h7FFF ^ {15{ra[0]}}};
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           ra, rb, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
